// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types and constants for the WS2812 frame scheduler
//
// Purpose: scheduler state encoding, colour-byte type and the default frame
// geometry shared by ws2812_frame_scheduler and its testbench.
// Ports: none (package).

package ws2812_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_STREAM,
      ST_HOLDOFF
   } sched_state_t;

   // Colour bytes per LED; the source maps rgb_index 0..2 onto GRB order.
   localparam int BYTES_PER_LED = 3;

   localparam int DEFAULT_LEDS           = 40;
   localparam int DEFAULT_HOLDOFF_CYCLES = 1200000;

   typedef logic [7:0] color_byte_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with pointer update strobe
//
// Purpose: picks a one-hot winner between two level requests. On a tie the
// source that was not served last wins; a sole requester always wins.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     request levels
//   update       strobe: record served_src as the last source served
//   served_src   index of the source just served (0 or 1)
//   grant[1:0]   combinational one-hot winner (0 when no request)

module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served_src,
   output logic [1:0] grant
);

   // Index of the last served source. Reset to 1 so source 0 wins the first tie.
   logic last_src;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_src ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_src <= 1'b1;
      end else if (update) begin
         last_src <= served_src;
      end
   end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// rtl/ws2812_frame_scheduler.sv - frame-level arbitration and byte sequencing for ws2812_output
//
// Purpose: grants one of two pixel sources, walks led_index/rgb_index over a
// full frame, registers each returned byte for the driver and enforces the
// latch holdoff between frames.
// Optional feature macro: WS2812_SCHED_STATS_EN adds frame_count[15:0].
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   src_req[1:0]         per-source frame request (level)
//   src_grant[1:0]       one-hot grant held for the whole frame
//   src_frame_done[1:0]  one-cycle pulse to the granted source after its last byte
//   led_index            LED currently addressed
//   rgb_index[1:0]       byte within the LED, 0..2
//   src0_data/src1_data  bytes from the sources, combinational on the indices
//   drv_start            one-cycle pulse launching the driver
//   drv_data[7:0]        registered byte presented to the driver
//   drv_data_req         driver pulse: drv_data consumed, prepare the next byte
//   frame_count[15:0]    completed frames, wraps (WS2812_SCHED_STATS_EN only)

module ws2812_frame_scheduler
   import ws2812_pkg::*;
#(
   parameter int LEDS           = DEFAULT_LEDS,
   parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
   localparam int LED_W         = (LEDS > 1) ? $clog2(LEDS) : 1,
   localparam int HOLD_W        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        src_req,
   output logic [1:0]        src_grant,
   output logic [1:0]        src_frame_done,
   output logic [LED_W-1:0]  led_index,
   output logic [1:0]        rgb_index,
   input  color_byte_t       src0_data,
   input  color_byte_t       src1_data,
   output logic              drv_start,
   output color_byte_t       drv_data,
   input  logic              drv_data_req
`ifdef WS2812_SCHED_STATS_EN
   ,
   output logic [15:0]       frame_count
`endif
);

   localparam logic [LED_W-1:0]  LAST_LED = LED_W'(LEDS - 1);
   localparam logic [1:0]        LAST_RGB = 2'(BYTES_PER_LED - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES - 1);

   sched_state_t      state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              load_pending;   // indices moved last cycle; capture the new byte now
   logic [1:0]        arb_grant;
   logic              is_last;
   logic              frame_end;
   color_byte_t       src_byte;

   // Only the granted source is ever looked at.
   assign src_byte  = src_grant[1] ? src1_data : src0_data;
   assign is_last   = (led_index == LAST_LED) && (rgb_index == LAST_RGB);
   assign frame_end = (state == ST_STREAM) && drv_data_req && is_last;

   rr_arbiter2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (src_req),
      .update     (frame_end),
      .served_src (src_grant[1]),
      .grant      (arb_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         src_grant      <= 2'b00;
         src_frame_done <= 2'b00;
         drv_start      <= 1'b0;
         drv_data       <= '0;
         led_index      <= '0;
         rgb_index      <= 2'd0;
         hold_cnt       <= '0;
         load_pending   <= 1'b0;
      end else begin
         drv_start      <= 1'b0;
         src_frame_done <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (|src_req) begin
                  src_grant <= arb_grant;
                  led_index <= '0;
                  rgb_index <= 2'd0;
                  state     <= ST_LOAD;
               end
            end
            // The source has had a cycle to settle on index 0; capture it so the
            // byte and the drv_start pulse are both visible during START.
            ST_LOAD: begin
               drv_data  <= src_byte;
               drv_start <= 1'b1;
               state     <= ST_START;
            end
            ST_START: begin
               load_pending <= 1'b0;
               state        <= ST_STREAM;
            end
            ST_STREAM: begin
               if (load_pending) begin
                  drv_data     <= src_byte;
                  load_pending <= 1'b0;
               end
               if (drv_data_req) begin
                  if (is_last) begin
                     src_frame_done <= src_grant;
                     src_grant      <= 2'b00;
                     led_index      <= '0;
                     rgb_index      <= 2'd0;
                     hold_cnt       <= HOLD_INIT;
                     state          <= ST_HOLDOFF;
                  end else begin
                     load_pending <= 1'b1;
                     if (rgb_index == LAST_RGB) begin
                        rgb_index <= 2'd0;
                        led_index <= led_index + LED_W'(1);
                     end else begin
                        rgb_index <= rgb_index + 2'd1;
                     end
                  end
               end
            end
            ST_HOLDOFF: begin
               if (hold_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef WS2812_SCHED_STATS_EN
   // Counts in step with the src_frame_done pulse being registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count <= 16'h0000;
      end else if (frame_end) begin
         frame_count <= frame_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// tb/tb_ws2812_frame_scheduler.sv - directed scoreboard bench for ws2812_frame_scheduler

module tb_ws2812_frame_scheduler;

   localparam int LEDS = 4;
   localparam int HOLD = 10;
   localparam int NB   = LEDS * 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  src_req = 2'b00;
   logic [1:0]  src_grant;
   logic [1:0]  src_frame_done;
   logic [1:0]  led_index;
   logic [1:0]  rgb_index;
   logic [7:0]  src0_data;
   logic [7:0]  src1_data;
   logic        drv_start;
   logic [7:0]  drv_data;
   logic        drv_data_req = 1'b0;
`ifdef WS2812_SCHED_STATS_EN
   logic [15:0] frame_count;
`endif

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   logic rr_last = 1'b1;   // model: last source served, 1 => source 0 wins a tie
   int frames = 0;

   always #5 clk = ~clk;

   // Pixel sources: byte value encodes the source and the flat byte index.
   always_comb begin
      src0_data = 8'h10 + 8'(int'(led_index) * 3 + int'(rgb_index));
      src1_data = 8'hA0 + 8'(int'(led_index) * 3 + int'(rgb_index));
   end

   ws2812_frame_scheduler #(.LEDS(LEDS), .HOLDOFF_CYCLES(HOLD)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .src_req        (src_req),
      .src_grant      (src_grant),
      .src_frame_done (src_frame_done),
      .led_index      (led_index),
      .rgb_index      (rgb_index),
      .src0_data      (src0_data),
      .src1_data      (src1_data),
      .drv_start      (drv_start),
      .drv_data       (drv_data),
      .drv_data_req   (drv_data_req)
`ifdef WS2812_SCHED_STATS_EN
      ,
      .frame_count    (frame_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] model_grant(input logic [1:0] r);
      if (r == 2'b11) return rr_last ? 2'b01 : 2'b10;
      return r;
   endfunction

   // Runs one frame starting from IDLE with src_req already driven.
   // drop_after: bytes after which src_req is released (0 = never).
   // stop_after: bytes after which the task returns mid-frame (0 = never).
   // noise: pulse drv_data_req through HOLDOFF and the following IDLE cycle.
   task automatic do_frame(input int drop_after, input int stop_after, input bit noise);
      logic [1:0] eg;
      logic [7:0] eb;
      int w;
      int src;
      eg  = model_grant(src_req);
      src = (eg == 2'b10) ? 1 : 0;
      for (int k = 0; k < NB; k++) exp_q.push_back(src ? (8'hA0 + 8'(k)) : (8'h10 + 8'(k)));
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (src_grant == 2'b00 && w < 20);
      drv_data_req = 1'b0;
      chk("grant_latency", w, 1);
      chk("grant", src_grant, eg);
      @(negedge clk);
      chk("drv_start", drv_start, 1);
      @(negedge clk);
      chk("drv_start_pulse", drv_start, 0);
      for (int k = 0; k < NB; k++) begin
         repeat (4) @(negedge clk);
         drv_data_req = 1'b1;
         chk("led_index", led_index, k / 3);
         chk("rgb_index", rgb_index, k % 3);
         chk("grant_hold", src_grant, eg);
         eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk("drv_data", drv_data, eb);
         @(negedge clk);
         drv_data_req = 1'b0;
         if (k + 1 == drop_after) src_req = 2'b00;
         if (k + 1 == stop_after) begin
            exp_q.delete();
            return;
         end
         if (k + 1 < NB) chk("frame_done_early", src_frame_done, 0);
      end
      chk("frame_done", src_frame_done, eg);
      chk("grant_drop", src_grant, 0);
      chk("led_clear", led_index, 0);
      chk("rgb_clear", rgb_index, 0);
      rr_last = src[0];
      frames++;
      for (int i = 2; i <= HOLD; i++) begin
         @(negedge clk);
         drv_data_req = noise & i[0];
         chk("holdoff_done", src_frame_done, 0);
         chk("holdoff_grant", src_grant, 0);
         chk("holdoff_led", led_index, 0);
         chk("holdoff_rgb", rgb_index, 0);
      end
      @(negedge clk);
      chk("idle_grant", src_grant, 0);
      drv_data_req = noise;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_grant", src_grant, 0);
      chk("rst_done", src_frame_done, 0);
      chk("rst_start", drv_start, 0);
      chk("rst_data", drv_data, 0);
      chk("rst_led", led_index, 0);
      chk("rst_rgb", rgb_index, 0);
      rst_n = 1'b1;

      // drv_data_req in IDLE is ignored
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drv_data_req = 1'b1;
         @(negedge clk);
         drv_data_req = 1'b0;
         chk("idle_req_led", led_index, 0);
         chk("idle_req_rgb", rgb_index, 0);
         chk("idle_req_grant", src_grant, 0);
      end

      // single requester, source 0, with holdoff noise
      src_req = 2'b01;
      do_frame(0, 0, 1'b1);
      src_req = 2'b00;
      drv_data_req = 1'b0;
      @(negedge clk);
      chk("idle_after_t1", src_grant, 0);

      // both requesting: four alternating frames
      src_req = 2'b11;
      for (int f = 0; f < 4; f++) do_frame(0, 0, 1'b0);
      src_req = 2'b00;
      drv_data_req = 1'b0;

      // source 1 drops its request mid-frame
      @(negedge clk);
      src_req = 2'b10;
      do_frame(5, 0, 1'b0);
      drv_data_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_no_grant", src_grant, 0);
      end

      // reset mid-frame
      src_req = 2'b11;
      do_frame(0, 5, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_grant", src_grant, 0);
      chk("midrst_data", drv_data, 0);
      chk("midrst_led", led_index, 0);
      chk("midrst_rgb", rgb_index, 0);
      chk("midrst_start", drv_start, 0);
      chk("midrst_done", src_frame_done, 0);
      rr_last = 1'b1;
      frames = 0;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_hold_done", src_frame_done, 0);
      end
      src_req = 2'b11;
      rst_n = 1'b1;
      do_frame(0, 0, 1'b0);
      chk("post_rst_first_src", rr_last, 0);

`ifdef WS2812_SCHED_STATS_EN
      do_frame(0, 0, 1'b0);
      do_frame(0, 0, 1'b0);
      chk("frame_count", frame_count, 16'(frames));
      src_req = 2'b00;
      drv_data_req = 1'b0;
      force dut.frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count;
      src_req = 2'b01;
      do_frame(0, 0, 1'b0);
      chk("frame_count_wrap", frame_count, 16'h0000);
`endif

      src_req = 2'b00;
      drv_data_req = 1'b0;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
Frame-level controller for the WS2812 output driver. It arbitrates between two pixel sources and sequences one complete LED frame from the granted source into the driver. It supplies LED and colour-byte indices to that source, registers the returned bytes, and enforces the latch holdoff between frames. It sits between the pattern generators (fader, override buffer) and ws2812_output.

Parameters:
LEDS, 40, LEDs per frame (≥1)
BYTES_PER_LED, 3, colour bytes per LED (fixed 3; source maps index→GRB order)
HOLDOFF_CYCLES, 1200000, clk cycles spent in HOLDOFF after each frame (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
src_req  in  2  per-source frame request, level
src_grant  out  2  one-hot grant, held for the whole frame
src_frame_done  out  2  one-cycle pulse to the granted source when its last byte is consumed
led_index  out  $clog2(LEDS)  LED currently addressed
rgb_index  out  2  byte within LED, 0..2
src0_data  in  8  byte from source 0, combinational on led_index/rgb_index
src1_data  in  8  byte from source 1, same timing as src0_data
drv_start  out  1  one-cycle pulse that launches the driver
drv_data  out  8  registered byte presented to the driver
drv_data_req  in  1  driver pulse: drv_data consumed this cycle, prepare next

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; src_grant=0; src_frame_done=0; drv_start=0; drv_data=0; led_index=0; rgb_index=0.
  - Round-robin pointer points at source 0, so source 0 wins first.
- States: IDLE, LOAD, START, STREAM, HOLDOFF.
- IDLE:
  - If any src_req is high, register the one-hot winner into src_grant, clear the indices, go to LOAD.
  - Round-robin rule: the source not granted last wins a tie. A sole requester always wins.
- LOAD: one cycle for the source to settle on index 0. Go to START.
- START:
  - drv_data ← the granted source's data; drv_start=1 for this cycle only.
  - Go to STREAM.
- STREAM, on drv_data_req:
  - Not the last byte: cycle t+1 advances rgb_index (0→1→2→0 with led_index+1). Cycle t+2 drv_data ← new source byte.
  - Driver contract: at least 4 cycles between drv_data_req pulses.
  - Last byte (led_index=LEDS-1, rgb_index=2): cycle t+1 pulses src_frame_done for the granted source, drops src_grant, clears the indices, loads the holdoff counter with HOLDOFF_CYCLES-1, and enters HOLDOFF.
- HOLDOFF:
  - Counter decrements each cycle; at 0 go to IDLE. HOLDOFF therefore lasts exactly HOLDOFF_CYCLES cycles.
  - The round-robin pointer updates to the source just served.
- A frame always delivers exactly LEDS*3 bytes. src_req falling mid-frame has no effect; the grant holds until the frame ends.
- drv_data_req outside STREAM is ignored: no index change, no state change.
- The non-granted source's data is never sampled.
- Reset asserted mid-frame: immediate return to reset values; no src_frame_done is issued.
- Index arithmetic: led_index is compared against LEDS-1 at its exact width, so there is no wrap beyond LEDS-1.

Optional Feature:
WS2812_SCHED_STATS_EN
- Defined: adds output frame_count[15:0], reset 0. It increments by 1 in the cycle src_frame_done is pulsed and wraps 0xFFFF→0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ws2812_pkg holds:
  - the state enum for IDLE/LOAD/START/STREAM/HOLDOFF;
  - BYTES_PER_LED=3;
  - an 8-bit colour-byte typedef;
  - the default LEDS/HOLDOFF_CYCLES constants shared with the top level.
- One sub-module: rr_arbiter2. It is a 2-way round-robin arbiter with an update strobe, used in IDLE, with the pointer updated at HOLDOFF entry.

Test Plan:
All scenarios use LEDS=4, HOLDOFF_CYCLES=10, and the driver model pulses drv_data_req every 5 cycles.
1. src_req=01 asserted at cycle N → src_grant=01 at N+1, drv_start at N+2, 12 drv_data_req consume bytes matching src0 for (led,rgb)=(0,0)…(3,2) → src_frame_done=01 one cycle after the 12th req, then 10 HOLDOFF cycles, then IDLE.
2. src_req=11 held constantly → grants alternate 01,10,01,10 over four frames, each frame exactly 12 bytes.
3. src_req=10 dropped after 5 bytes → frame still completes 12 bytes with grant 10 held; then IDLE with no grant.
4. drv_data_req pulsed during IDLE and HOLDOFF → led_index/rgb_index stay 0, the state sequence is unchanged, and HOLDOFF is still exactly 10 cycles.
5. rst_n low after byte 5 of a frame → same cycle src_grant=0, drv_data=0, indices 0, no frame_done; after release with src_req=11, source 0 is granted first.
6. With WS2812_SCHED_STATS_EN defined, three frames sent → frame_count=3. With frame_count forced near wrap at 0xFFFF, one more frame → 0x0000.
